// File: rtl/hack_pkg.sv
// hack_pkg: shared ctrl bit indices, Hack ALU opcodes and result flag struct.
package hack_pkg;
    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    localparam logic [5:0] OP_ZERO      = 6'b101010;
    localparam logic [5:0] OP_ONE       = 6'b111111;
    localparam logic [5:0] OP_NEG1      = 6'b111010;
    localparam logic [5:0] OP_X         = 6'b001100;
    localparam logic [5:0] OP_Y         = 6'b110000;
    localparam logic [5:0] OP_NOT_X     = 6'b001101;
    localparam logic [5:0] OP_NOT_Y     = 6'b110001;
    localparam logic [5:0] OP_NEG_X     = 6'b001111;
    localparam logic [5:0] OP_NEG_Y     = 6'b110011;
    localparam logic [5:0] OP_X_PLUS_1  = 6'b011111;
    localparam logic [5:0] OP_Y_PLUS_1  = 6'b110111;
    localparam logic [5:0] OP_X_MINUS_1 = 6'b001110;
    localparam logic [5:0] OP_Y_MINUS_1 = 6'b110010;
    localparam logic [5:0] OP_X_PLUS_Y  = 6'b000010;
    localparam logic [5:0] OP_X_MINUS_Y = 6'b010011;
    localparam logic [5:0] OP_Y_MINUS_X = 6'b000111;
    localparam logic [5:0] OP_X_AND_Y   = 6'b000000;
    localparam logic [5:0] OP_X_OR_Y    = 6'b010101;

    typedef struct packed {
        logic zr;
        logic ng;
        logic cy;
        logic ov;
    } flags_t;
endpackage

// File: rtl/hack_alu_core.sv
// hack_alu_core: combinational Hack function stage on preset operands, with
// carry/overflow taken from the full-width adder before the output inversion.
module hack_alu_core
    import hack_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] res,
    output flags_t           flags
);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] fres;

    always_comb begin
        sum      = {1'b0, x1} + {1'b0, y1};
        fres     = f ? sum[WIDTH-1:0] : x1 & y1;
        res      = no ? ~fres : fres;
        flags.zr = res == '0;
        flags.ng = res[WIDTH-1];
        flags.cy = f & sum[WIDTH];
        flags.ov = f & (x1[WIDTH-1] == y1[WIDTH-1]) & (sum[WIDTH-1] != x1[WIDTH-1]);
    end
endmodule

// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage valid/ready Hack ALU; s1 holds preset operands,
// s2 holds the result and flags. No skid buffer, so occupancy is at most 2.
module hack_alu_pipe
    import hack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [5:0]       in_ctrl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zr,
    output logic             out_ng,
    output logic             out_cy,
    output logic             out_ov,
    output logic [TAG_W-1:0] out_tag
);
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s1_load, s2_load;
    logic             s1_f_q, s1_f_d, s1_no_q, s1_no_d;
    logic [WIDTH-1:0] x_zero, y_zero, s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [WIDTH-1:0] core_res, s2_res_q, s2_res_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    flags_t           core_flags, s2_flags_q, s2_flags_d;

    hack_alu_core #(.WIDTH(WIDTH)) u_core (
        .x1    (s1_x_q),
        .y1    (s1_y_q),
        .f     (s1_f_q),
        .no    (s1_no_q),
        .res   (core_res),
        .flags (core_flags)
    );

    always_comb begin
        x_zero     = in_ctrl[CTRL_ZX] ? '0 : in_x;
        y_zero     = in_ctrl[CTRL_ZY] ? '0 : in_y;
        s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready   = !s1_valid_q || s2_load;
        s1_load    = in_valid && in_ready;
        s1_valid_d = s1_load || (s1_valid_q && !s2_load);
        s2_valid_d = s2_load || (s2_valid_q && !out_ready);
        s1_x_d     = s1_load ? (in_ctrl[CTRL_NX] ? ~x_zero : x_zero) : s1_x_q;
        s1_y_d     = s1_load ? (in_ctrl[CTRL_NY] ? ~y_zero : y_zero) : s1_y_q;
        s1_f_d     = s1_load ? in_ctrl[CTRL_F] : s1_f_q;
        s1_no_d    = s1_load ? in_ctrl[CTRL_NO] : s1_no_q;
        s1_tag_d   = s1_load ? in_tag : s1_tag_q;
        s2_res_d   = s2_load ? core_res : s2_res_q;
        s2_flags_d = s2_load ? core_flags : s2_flags_q;
        s2_tag_d   = s2_load ? s1_tag_q : s2_tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_f_q     <= 1'b0;
            s1_no_q    <= 1'b0;
            s1_tag_q   <= '0;
            s2_res_q   <= '0;
            s2_flags_q <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_f_q     <= s1_f_d;
            s1_no_q    <= s1_no_d;
            s1_tag_q   <= s1_tag_d;
            s2_res_q   <= s2_res_d;
            s2_flags_q <= s2_flags_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_zr    = s2_flags_q.zr;
    assign out_ng    = s2_flags_q.ng;
    assign out_cy    = s2_flags_q.cy;
    assign out_ov    = s2_flags_q.ov;
    assign out_tag   = s2_tag_q;
endmodule
